// File: rtl/dsp_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// dsp_mul_share_arbiter
//
// Shares one external pipelined DSP multiplier among NUM_REQ requesters.
// A round-robin arbiter issues at most one operand pair per cycle. The winning
// requester's operands are muxed onto dsp_a/dsp_b. A tag pipeline of
// {valid, id} runs in lockstep with the DSP registers, so every product that
// leaves the DSP carries the index of its owner. Results leave on one
// valid/ready channel. Backpressure freezes the DSP and the tag pipeline
// through dsp_ce.
//
// Optional feature: define DSP_ARB_PRIORITY_EN to make requester 0
// strict-priority. Requesters 1..NUM_REQ-1 then round-robin among themselves.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester operand valid            [NUM_REQ]
//   req_ready  one-hot grant                          [NUM_REQ]
//   req_a      packed operand A, lane k at [k*DATA_W +: DATA_W]
//   req_b      packed operand B, same packing
//   dsp_a      operand A to the DSP                   [DATA_W]
//   dsp_b      operand B to the DSP                   [DATA_W]
//   dsp_ce     clock enable for every DSP register
//   dsp_p      DSP product                            [2*DATA_W]
//   res_valid  result valid
//   res_ready  result consumer ready
//   res_p      result product (wired from dsp_p)      [2*DATA_W]
//   res_id     owner of res_p                         [ID_W]
//   inflight   number of valid tags in the pipeline   [3]
// -----------------------------------------------------------------------------
module dsp_mul_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 16,
    parameter int PIPELINE_DEPTH = 2,
    parameter int ID_W           = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]           dsp_a,
    output logic [DATA_W-1:0]           dsp_b,
    output logic                        dsp_ce,
    input  logic [2*DATA_W-1:0]         dsp_p,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2*DATA_W-1:0]         res_p,
    output logic [ID_W-1:0]             res_id,
    output logic [2:0]                  inflight
);

`ifdef DSP_ARB_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    // Requester 0 is taken out of the round-robin scan when it has strict priority.
    localparam logic [NUM_REQ-1:0] PRIO_MASK = PRIO_EN ? NUM_REQ'(1) : '0;

    logic                 live_q;        // low during reset and the cycle after it
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      rr_next;
    logic                 grant_allowed;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic [NUM_REQ-1:0]   rr_cand;
    logic [NUM_REQ-1:0]   rot_valid;
    int                   scan_sum;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    // The candidate vector is rotated so that bit 0 corresponds to rr_ptr.
    // The first set bit then gives the winner's distance from rr_ptr.
    assign rr_cand   = req_valid & ~PRIO_MASK;
    assign rot_valid = NUM_REQ'({rr_cand, rr_cand} >> rr_ptr);

    // NOTE: every signal driven here gets a default first, so no latch is
    // inferred on paths that skip an assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_sum    = 0;
        if (grant_allowed) begin
            if (PRIO_EN && req_valid[0]) begin
                grant_valid = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && rot_valid[i]) begin
                    grant_valid = 1'b1;
                    scan_sum    = int'(rr_ptr) + i;
                    if (scan_sum >= NUM_REQ) begin
                        scan_sum = scan_sum - NUM_REQ;
                    end
                    grant_id = ID_W'(scan_sum);
                end
            end
        end
    end

    // One-hot grant and operand mux. Both depend only on the grant, never on
    // the operand values.
    always_comb begin
        req_ready = '0;
        dsp_a     = '0;
        dsp_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_valid && grant_id == ID_W'(k)) begin
                req_ready[k] = 1'b1;
                dsp_a        = req_a[k*DATA_W +: DATA_W];
                dsp_b        = req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // A grant only happens when the pipeline can move, so a grant alone
    // qualifies the pointer update. Priority grants leave the pointer alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid && !(PRIO_EN && grant_id == '0)) begin
            rr_ptr <= rr_next;
        end
    end

    assign res_p = dsp_p;

    // ------------------------------------------------------------------
    // Tag pipeline / stall control
    // ------------------------------------------------------------------
    generate
        if (PIPELINE_DEPTH == 0) begin : g_comb
            // A combinational DSP never stalls. The consumer must be ready
            // in the very cycle an operand pair is accepted.
            assign dsp_ce        = 1'b1;
            assign grant_allowed = rst_n && live_q && res_ready;
            assign res_valid     = grant_valid;
            assign res_id        = grant_id;
            assign inflight      = 3'd0;
        end else begin : g_pipe
            logic [PIPELINE_DEPTH-1:0] tag_valid;
            logic [ID_W-1:0]           tag_id [PIPELINE_DEPTH];
            logic [2:0]                valid_count;

            // Gating with rst_n forces res_valid low while reset is applied,
            // before the tag valids have been cleared.
            assign res_valid     = tag_valid[PIPELINE_DEPTH-1] && rst_n;
            assign res_id        = tag_id[PIPELINE_DEPTH-1];
            assign dsp_ce        = !res_valid || res_ready;
            assign grant_allowed = rst_n && live_q && dsp_ce;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_valid <= '0;
                end else if (dsp_ce) begin
                    tag_valid[0] <= grant_valid;
                    for (int n = 1; n < PIPELINE_DEPTH; n++) begin
                        tag_valid[n] <= tag_valid[n-1];
                    end
                end
            end

            // NOTE: the id stages carry no reset. Each id is only looked at
            // while its valid bit is set, and only the valid bits are cleared.
            always_ff @(posedge clk) begin
                if (dsp_ce) begin
                    tag_id[0] <= grant_id;
                    for (int n = 1; n < PIPELINE_DEPTH; n++) begin
                        tag_id[n] <= tag_id[n-1];
                    end
                end
            end

            always_comb begin
                valid_count = '0;
                for (int n = 0; n < PIPELINE_DEPTH; n++) begin
                    valid_count = valid_count + 3'(tag_valid[n]);
                end
            end

            assign inflight = valid_count;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dsp_mul_share_arbiter.
// Main instance: depth 2, with a behavioural two-stage DSP. Second instance:
// depth 0, with a combinational DSP. A reference model tracks grant order
// with an integer pointer. It also keeps a queue of outstanding products, each
// stamped with the enable count at issue, and a product is due when it has
// aged PIPELINE_DEPTH enabled cycles.
// -----------------------------------------------------------------------------
module tb_dsp_mul_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D  = 2;
    localparam int IW = 2;

`ifdef DSP_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;

    // depth-2 instance
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   dsp_a, dsp_b;
    logic           dsp_ce;
    logic [2*W-1:0] dsp_p;
    logic           res_valid, res_ready;
    logic [2*W-1:0] res_p;
    logic [IW-1:0]  res_id;
    logic [2:0]     inflight;

    // depth-0 instance
    logic [N-1:0]   z_req_valid;
    logic [N-1:0]   z_req_ready;
    logic [N*W-1:0] z_req_a, z_req_b;
    logic [W-1:0]   z_dsp_a, z_dsp_b;
    logic           z_dsp_ce;
    logic [2*W-1:0] z_dsp_p;
    logic           z_res_valid, z_res_ready;
    logic [2*W-1:0] z_res_p;
    logic [IW-1:0]  z_res_id;
    logic [2:0]     z_inflight;

    dsp_mul_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .PIPELINE_DEPTH(D), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce),
        .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
        .res_id(res_id), .inflight(inflight)
    );

    dsp_mul_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .PIPELINE_DEPTH(0), .ID_W(IW)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_a(z_req_a), .req_b(z_req_b), .dsp_a(z_dsp_a), .dsp_b(z_dsp_b), .dsp_ce(z_dsp_ce),
        .dsp_p(z_dsp_p), .res_valid(z_res_valid), .res_ready(z_res_ready), .res_p(z_res_p),
        .res_id(z_res_id), .inflight(z_inflight)
    );

    // External DSPs: a two-register multiplier gated by dsp_ce, and a
    // purely combinational one for the depth-0 instance.
    logic [2*W-1:0] dsp_s1, dsp_s2;
    always @(posedge clk) begin
        if (dsp_ce) begin
            dsp_s1 <= 32'(dsp_a) * 32'(dsp_b);
            dsp_s2 <= dsp_s1;
        end
    end
    assign dsp_p   = dsp_s2;
    assign z_dsp_p = 32'(z_dsp_a) * 32'(z_dsp_b);

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [31:0] p;
        int          issue;
    } item_t;

    item_t q[$];
    int    rr;
    int    ce_count;
    bit    live;
    bit    m_valid, m_ce, m_gv;
    int    m_gid;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] opnd(input logic [N*W-1:0] bus, input int k);
        return W'(bus >> (k * W));
    endfunction

    // Compute the expected behaviour for this cycle and compare it with the
    // depth-2 instance. Outputs are sampled at the falling edge.
    task automatic sample();
        @(negedge clk);
        m_valid = 1'b0;
        if (rst_n && q.size() > 0) begin
            m_valid = (ce_count - q[0].issue == D);
        end
        m_ce  = !m_valid || res_ready;
        m_gv  = 1'b0;
        m_gid = 0;
        if (rst_n && live && m_ce) begin
            if (PRIO && req_valid[0]) begin
                m_gv  = 1'b1;
                m_gid = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (rr + i) % N;
                    if (!m_gv && req_valid[k] && !(PRIO && k == 0)) begin
                        m_gv  = 1'b1;
                        m_gid = k;
                    end
                end
            end
        end
        check("dsp_ce",    32'(dsp_ce),    32'(m_ce));
        check("req_ready", 32'(req_ready), m_gv ? (32'(1) << m_gid) : 32'(0));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid) begin
            check("res_p",  res_p,          q[0].p);
            check("res_id", 32'(res_id),    32'(q[0].id));
        end
        check("inflight", 32'(inflight), 32'(q.size()));
        check("dsp_a", 32'(dsp_a), m_gv ? 32'(opnd(req_a, m_gid)) : 32'(0));
        check("dsp_b", 32'(dsp_b), m_gv ? 32'(opnd(req_b, m_gid)) : 32'(0));
    endtask

    // Step across the rising edge and advance the model with the same inputs.
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rr   = 0;
            live = 1'b0;
        end else begin
            if (m_valid && res_ready) begin
                void'(q.pop_front());
            end
            if (m_ce) begin
                if (m_gv) begin
                    q.push_back('{id: m_gid,
                                  p: 32'(opnd(req_a, m_gid)) * 32'(opnd(req_b, m_gid)),
                                  issue: ce_count});
                end
                ce_count++;
            end
            if (m_gv && !(PRIO && m_gid == 0)) begin
                rr = (m_gid + 1) % N;
            end
            live = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        res_ready   = 1'b1;
        z_req_valid = '0;
        z_req_a     = '0;
        z_req_b     = '0;
        z_res_ready = 1'b0;
        rr          = 0;
        ce_count    = 0;
        live        = 1'b0;

        repeat (2) @(posedge clk);
        #1;

        // Reset state, then the cycle after reset: no grant even with requests.
        cycle();
        rst_n     = 1'b1;
        req_valid = '1;
        sample();
        check("post_rst_ready", 32'(req_ready), 32'(0));
        check("post_rst_ce",    32'(dsp_ce),    32'(1));
        advance();
        req_valid = '0;
        cycle();

        // Single requester: lane 2, 7*9.
        req_a[2*W +: W] = 16'd7;
        req_b[2*W +: W] = 16'd9;
        req_valid       = 4'b0100;
        sample();
        check("single_grant", 32'(req_ready), 32'h4);
        advance();
        req_valid = '0;
        sample();
        check("single_inflight", 32'(inflight), 32'd1);
        advance();
        sample();
        check("single_res_valid", 32'(res_valid), 32'd1);
        check("single_res_p",     res_p,          32'd63);
        check("single_res_id",    32'(res_id),    32'd2);
        advance();

        // Reset mid-flight: grant lane 1 (3*5), then reset the next cycle.
        req_a[1*W +: W] = 16'd3;
        req_b[1*W +: W] = 16'd5;
        req_valid       = 4'b0010;
        cycle();
        req_valid = '0;
        rst_n     = 1'b0;
        sample();
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_ce",        32'(dsp_ce),    32'd1);
        advance();
        rst_n = 1'b1;
        sample();
        check("midrst_inflight", 32'(inflight), 32'd0);
        advance();
        sample();
        check("midrst_no_result", 32'(res_valid), 32'd0);
        advance();

        // Fairness: all requesters valid, pointer freshly reset to 0.
        req_a     = {$urandom(), $urandom()};
        req_b     = {$urandom(), $urandom()};
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            sample();
`ifndef DSP_ARB_PRIORITY_EN
            check("fair_grant", 32'(req_ready), 32'(1) << (i % 4));
            if (i >= 2) begin
                check("fair_res_id", 32'(res_id), 32'((i - 2) % 4));
            end
`endif
            advance();
        end

        // Backpressure: stream lanes 0/1, stall three cycles, then drain.
        req_valid = 4'b0011;
        res_ready = 1'b1;
        repeat (4) cycle();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_ce",    32'(dsp_ce),    32'd0);
            advance();
        end
        res_ready = 1'b1;
        repeat (3) cycle();
        req_valid = '0;
        repeat (4) cycle();
        check("bp_drained", 32'(inflight), 32'd0);

`ifdef DSP_ARB_PRIORITY_EN
        // Strict priority: lane 0 wins every cycle, lane 1 takes over after.
        req_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("prio_grant0", 32'(req_ready), 32'h1);
            advance();
        end
        req_valid = 4'b0010;
        sample();
        check("prio_grant1", 32'(req_ready), 32'h2);
        advance();
        req_valid = '0;
        repeat (3) cycle();
`endif

        // Depth-0 instance: lane 3, 16'hFFFF * 2.
        z_req_a[3*W +: W] = 16'hFFFF;
        z_req_b[3*W +: W] = 16'd2;
        z_req_valid       = 4'b1000;
        z_res_ready       = 1'b0;
        sample();
        check("d0_blocked_ready", 32'(z_req_ready), 32'd0);
        check("d0_blocked_valid", 32'(z_res_valid), 32'd0);
        check("d0_ce",            32'(z_dsp_ce),    32'd1);
        advance();
        z_res_ready = 1'b1;
        sample();
        check("d0_grant",     32'(z_req_ready), 32'h8);
        check("d0_res_valid", 32'(z_res_valid), 32'd1);
        check("d0_res_p",     z_res_p,          32'h0001_FFFE);
        check("d0_res_id",    32'(z_res_id),    32'd3);
        check("d0_inflight",  32'(z_inflight),  32'd0);
        advance();
        z_req_valid = '0;

        // Randomised traffic with one reset pulse in the middle.
        for (int c = 0; c < 400; c++) begin
            rst_n     = (c != 200);
            req_valid = 4'($urandom());
            req_a     = {$urandom(), $urandom()};
            req_b     = {$urandom(), $urandom()};
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) cycle();
        check("final_drained", 32'(inflight), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mul_share_arbiter.md
Name: dsp_mul_share_arbiter

Overview:
- Shares one external pipelined DSP multiplier (latency PIPELINE_DEPTH, clock-enable gated) among NUM_REQ requesters.
- Round-robin arbitration, at most one issue per cycle.
- Operands are muxed onto the DSP inputs, and a requester-ID tag pipeline runs in lockstep with the DSP.
- Products return on a single shared result channel with a valid/ready handshake; backpressure stalls the DSP through dsp_ce.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width.
- PIPELINE_DEPTH, 2, DSP register stages from dsp_a/dsp_b to dsp_p (0..4); must match the instantiated DSP.
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  one-hot grant; a handshake occurs when req_valid[k] && req_ready[k].
- req_a  input  NUM_REQ*DATA_W  packed operand A; requester k at [k*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  packed operand B, same packing.
- dsp_a  output  DATA_W  operand A to the DSP.
- dsp_b  output  DATA_W  operand B to the DSP.
- dsp_ce  output  1  DSP clock enable for all DSP pipeline registers.
- dsp_p  input  2*DATA_W  DSP product output.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_p  output  2*DATA_W  result product; equals dsp_p.
- res_id  output  ID_W  index of the requester that owns res_p.
- inflight  output  3  number of valid tags currently in the tag pipeline (0..PIPELINE_DEPTH).

Behaviour:
- Reset (rst_n=0 at a clk edge): rr_ptr=0, all tag-stage valids=0, inflight=0. The following hold during reset and in the cycle after it:
  - res_valid=0, req_ready=0.
  - dsp_ce=1, to flush the DSP.
- Reset asserted mid-operation drops all in-flight results; no res_valid is produced for them.
- Stall rule:
  - PIPELINE_DEPTH>=1: dsp_ce = !res_valid || res_ready. With dsp_ce=0, no tag stage moves, no grant is issued (req_ready=0), and res_valid/res_p/res_id hold their values.
  - PIPELINE_DEPTH=0: dsp_ce=1 constantly. A grant requires res_ready=1, and res_valid is combinational from the grant.
- Arbitration (combinational, in any cycle a grant is allowed):
  - Scan from rr_ptr upward, modulo NUM_REQ. The first k with req_valid[k]=1 gets req_ready[k]=1.
  - dsp_a/dsp_b are driven from req_a/req_b of that requester.
  - With no grant, dsp_a=dsp_b=0.
- rr_ptr update: on a grant to k, rr_ptr <= (k+1) mod NUM_REQ at the next edge; otherwise unchanged. This ensures no requester waits more than NUM_REQ-1 grants.
- req_ready never depends on req_a/req_b.
- Tag pipeline:
  - PIPELINE_DEPTH stages, each {valid, id}. Stage 0 loads {grant_valid, grant_id} when dsp_ce=1; stage n loads from stage n-1 when dsp_ce=1.
  - res_valid = last stage valid; res_id = last stage id. For depth 0: res_valid = grant_valid, res_id = grant_id.
- Latency: a product appears on res_* exactly PIPELINE_DEPTH enabled cycles after its handshake. Full throughput is 1 result/cycle while res_ready=1.
- Ordering: results return in grant order. The same requester may have several results in flight.
- inflight = popcount of tag-stage valids (0 for depth 0).
- Simultaneous events: a result handshake and a new grant in the same cycle are both allowed (pipeline shift). A requester deasserting req_valid without handshake is legal, and the arbiter re-evaluates each cycle.

Optional Feature:
- Macro DSP_ARB_PRIORITY_EN.
- When defined: requester 0 is strict-priority. Whenever req_valid[0]=1 and a grant is allowed, requester 0 wins regardless of rr_ptr, and rr_ptr is not updated on requester-0 grants. Requesters 1..NUM_REQ-1 keep round-robin among themselves.
- When undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset mid-flight: depth 2, grant req1 (3*5), assert rst_n=0 next cycle, release -> res_valid stays 0, inflight=0, rr_ptr=0.
- Single requester: depth 2, req2 a=7 b=9, res_ready=1 -> req_ready=4'b0100 in cycle 0; res_valid=1, res_p=63, res_id=2 in cycle 2; inflight=1 in cycle 1.
- Fairness: all 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1; res_id sequence identical, lagging 2 cycles.
- Backpressure: depth 2, stream grants to req0/req1, drop res_ready for 3 cycles while res_valid=1 -> dsp_ce=0, req_ready=0, res_p/res_id held; on release, results resume in order, none lost or duplicated.
- Depth 0: PIPELINE_DEPTH=0, req3 a=16'hFFFF b=2, res_ready=0 -> req_ready=0. With res_ready=1 -> same-cycle res_valid=1, res_p=32'h1FFFE, res_id=3.
- DSP_ARB_PRIORITY_EN defined: req0 and req1 valid continuously -> req0 granted every cycle. Drop req0 -> req1 granted next cycle.
